mdu_seq: RTL

Iterative RV32M multiply/divide sequencer for the single-cycle core. It latches the two ALU operands already selected by the operand muxes, runs a radix-2 shift-add/shift-subtract loop, and holds the core through a `stall` output until the result is ready. In the result cycle the core writes back `result` and advances the PC. The main ALU stays purely combinational; every M-extension instruction is routed through this block.

---
 rtl/mdu_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, stalling the core until result is ready.
module mdu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  op;
    logic [31:0] a_raw, b_raw;
    logic [31:0] a_mag, b_mag;
    logic        neg_a, neg_b;
    logic [63:0] acc;
    logic [5:0]  cnt;

    logic        is_div, sgn_a, sgn_b;
    logic        div_zero, div_ovf, special;
    logic [31:0] special_val;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_sub;
    logic [63:0] prod;
    logic [31:0] quo, rem;
    logic [31:0] fix_val;

    // Operation decode and the division special cases that bypass the loop.
    always_comb begin
        is_div   = op[2];
        sgn_a    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        sgn_b    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        div_zero = is_div && (b_raw == 32'd0);
        div_ovf  = ((op == 3'b100) || (op == 3'b110)) &&
                   (a_raw == 32'h8000_0000) && (b_raw == 32'hFFFF_FFFF);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_val = op[1] ? a_raw : 32'hFFFF_FFFF;
        else
            special_val = op[1] ? 32'd0 : 32'h8000_0000;
    end

    // One iteration step; the remainder lives in acc[63:32], quotient/product low half in acc[31:0].
    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + (b_mag[0] ? {1'b0, a_mag} : 33'd0);
        rem_sh  = {acc[63:32], a_mag[31]};
        rem_ge  = (rem_sh >= {1'b0, b_mag});
        rem_sub = rem_sh[31:0] - b_mag;
    end

    always_comb begin
        prod = (neg_a ^ neg_b) ? -acc : acc;
        quo  = (neg_a ^ neg_b) ? -acc[31:0] : acc[31:0];
        rem  = neg_a ? -acc[63:32] : acc[63:32];
        case (op)
            3'b000:                 fix_val = prod[31:0];
            3'b001, 3'b010, 3'b011: fix_val = prod[63:32];
            3'b100, 3'b101:         fix_val = quo;
            default:                fix_val = rem;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PREP;
            PREP:    state_nxt = special ? DONE : ITER;
            ITER:    if (cnt == 6'd31) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        stall = ((state == IDLE) && start) || (state == PREP) || (state == ITER) || (state == FIX);
        busy  = (state != IDLE);
        done  = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op     <= 3'd0;
            a_raw  <= 32'd0;
            b_raw  <= 32'd0;
            a_mag  <= 32'd0;
            b_mag  <= 32'd0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            acc    <= 64'd0;
            cnt    <= 6'd0;
            result <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        op    <= funct3;
                        a_raw <= opA;
                        b_raw <= opB;
                    end
                end
                PREP: begin
                    neg_a <= sgn_a && a_raw[31];
                    neg_b <= sgn_b && b_raw[31];
                    a_mag <= (sgn_a && a_raw[31]) ? -a_raw : a_raw;
                    b_mag <= (sgn_b && b_raw[31]) ? -b_raw : b_raw;
                    acc   <= 64'd0;
                    cnt   <= 6'd0;
                    if (special)
                        result <= special_val;
                end
                ITER: begin
                    cnt <= cnt + 6'd1;
                    if (is_div) begin
                        acc[63:32] <= rem_ge ? rem_sub : rem_sh[31:0];
                        acc[31:0]  <= {acc[30:0], rem_ge};
                        a_mag      <= a_mag << 1;
                    end else begin
                        acc   <= {mul_sum, acc[31:1]};
                        b_mag <= b_mag >> 1;
                    end
                end
                FIX:     result <= fix_val;
                default: ;
            endcase
        end
    end

endmodule
